// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch sequencer bus: PC control, instruction memory, decode handshake, redirect
interface instr_fetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] pc;
  logic [1:0]        pc_en;
  logic [ADDR_W-1:0] pc_newAdr;
  logic [ADDR_W-1:0] pc_imm;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;
  logic              instr_ready;
  logic              redirect;
  logic              redirect_br;
  logic [ADDR_W-1:0] redirect_adr;
  logic [ADDR_W-1:0] redirect_imm;

  modport master (
    input  pc, mem_rdata, instr_ready, redirect, redirect_br, redirect_adr, redirect_imm,
    output pc_en, pc_newAdr, pc_imm, mem_rd, mem_addr, instr, instr_pc, instr_valid
  );

  modport slave (
    output pc, mem_rdata, instr_ready, redirect, redirect_br, redirect_adr, redirect_imm,
    input  pc_en, pc_newAdr, pc_imm, mem_rd, mem_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch sequencer: PC-addressed memory read, instruction register, redirect to PC enable
module instr_fetch #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [1:0]        r_cnt;
  logic [ADDR_W-1:0] r_fetch_adr;
  logic [DATA_W-1:0] r_instr;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_instr_valid;
  logic              w_capture;
  logic              w_consume;

  // A redirect abandons whatever is in flight, so it also blocks the capture.
  assign w_capture = (r_state == S_WAIT) && (r_cnt == 2'd0) && !bus.redirect;
  assign w_consume = (r_state == S_HOLD) && r_instr_valid && bus.instr_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (bus.redirect) begin
      w_next = S_REQ;
    end else begin
      case (r_state)
        S_REQ:   w_next = S_WAIT;
        S_WAIT:  if (r_cnt == 2'd0) w_next = S_HOLD;
        S_HOLD:  if (w_consume) w_next = S_REQ;
        default: w_next = S_REQ;
      endcase
    end
  end

  always_comb begin
    bus.mem_rd    = 1'b0;
    bus.mem_addr  = '0;
    bus.pc_en     = 2'b00;
    bus.pc_newAdr = '0;
    bus.pc_imm    = '0;
    if (rst) begin
      if (r_state == S_REQ) begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = bus.pc;
      end
      if (bus.redirect) begin
        bus.pc_en     = bus.redirect_br ? 2'b11 : 2'b10;
        bus.pc_newAdr = bus.redirect_adr;
        bus.pc_imm    = bus.redirect_imm;
      end else if (w_capture) begin
        bus.pc_en = 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= 2'd0;
      r_fetch_adr   <= '0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      if (r_state == S_REQ) begin
        r_fetch_adr <= bus.pc;
        r_cnt       <= LAT_M1;
      end else if ((r_state == S_WAIT) && (r_cnt != 2'd0)) begin
        r_cnt <= r_cnt - 2'd1;
      end

      if (bus.redirect) begin
        r_instr_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr       <= bus.mem_rdata;
        r_instr_pc    <= r_fetch_adr;
        r_instr_valid <= 1'b1;
      end else if (w_consume) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign bus.instr_valid = r_instr_valid;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - three fetch sequencers (MEM_LAT 1/3/4) against a transaction-level model
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ready = 1'b0;
  logic        redir = 1'b0;
  logic        redir_br = 1'b0;
  logic [15:0] redir_adr = '0;
  logic [15:0] redir_imm = '0;

  logic [15:0] w_pc [3];
  logic [1:0]  w_pc_en [3];
  logic [15:0] w_newadr [3];
  logic [15:0] w_imm [3];
  logic        w_rd [3];
  logic [15:0] w_addr [3];
  logic [15:0] w_instr [3];
  logic [15:0] w_ipc [3];
  logic        w_valid [3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : ln
    localparam int L = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    logic [15:0] pc_q = '0;
    logic [16:0] pipe [4];

    instr_fetch_if #(.ADDR_W(16), .DATA_W(16)) ifc ();

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc.master)
    );

    assign ifc.pc           = pc_q;
    assign ifc.instr_ready  = ready;
    assign ifc.redirect     = redir;
    assign ifc.redirect_br  = redir_br;
    assign ifc.redirect_adr = redir_adr;
    assign ifc.redirect_imm = redir_imm;
    // memory answers with 0x1000+addr exactly L cycles after the read, garbage otherwise
    assign ifc.mem_rdata    = pipe[L-1][16] ? 16'(16'h1000 + pipe[L-1][15:0]) : 16'hDEAD;

    always @(posedge clk) begin
      pipe[0] <= {ifc.mem_rd, ifc.mem_addr};
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      case (ifc.pc_en)
        2'b01:   pc_q <= pc_q + 16'd1;
        2'b10:   pc_q <= ifc.pc_newAdr;
        2'b11:   pc_q <= pc_q + ifc.pc_imm;
        default: pc_q <= pc_q;
      endcase
    end

    assign w_pc[g]     = pc_q;
    assign w_pc_en[g]  = ifc.pc_en;
    assign w_newadr[g] = ifc.pc_newAdr;
    assign w_imm[g]    = ifc.pc_imm;
    assign w_rd[g]     = ifc.mem_rd;
    assign w_addr[g]   = ifc.mem_addr;
    assign w_instr[g]  = ifc.instr;
    assign w_ipc[g]    = ifc.instr_pc;
    assign w_valid[g]  = ifc.instr_valid;
  end

  task automatic chk(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d: got %0h, expected %0h", nm, lane, act, exp);
    end
  endtask

  // Model: per lane, a held instruction and at most one outstanding read with its age.
  logic        m_valid [3] = '{0, 0, 0};
  logic        m_pend  [3] = '{0, 0, 0};
  int          m_age   [3] = '{0, 0, 0};
  logic [15:0] m_fa    [3] = '{0, 0, 0};
  logic [15:0] m_instr [3] = '{0, 0, 0};
  logic [15:0] m_ipc   [3] = '{0, 0, 0};

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      int lat;
      logic rq, cp;
      logic [1:0] en;
      lat = (k == 0) ? 1 : ((k == 1) ? 3 : 4);
      if (!rst) begin
        chk("rst_mem_rd", k, 32'(w_rd[k]), 0);
        chk("rst_mem_addr", k, 32'(w_addr[k]), 0);
        chk("rst_pc_en", k, 32'(w_pc_en[k]), 0);
        chk("rst_newadr", k, 32'(w_newadr[k]), 0);
        chk("rst_imm", k, 32'(w_imm[k]), 0);
        chk("rst_valid", k, 32'(w_valid[k]), 0);
        chk("rst_instr", k, 32'(w_instr[k]), 0);
        chk("rst_ipc", k, 32'(w_ipc[k]), 0);
        m_valid[k] = 1'b0;
        m_pend[k]  = 1'b0;
        m_instr[k] = '0;
        m_ipc[k]   = '0;
      end else begin
        rq = !m_valid[k] && !m_pend[k];
        cp = m_pend[k] && (m_age[k] == lat);
        en = redir ? (redir_br ? 2'b11 : 2'b10) : (cp ? 2'b01 : 2'b00);
        chk("mem_rd", k, 32'(w_rd[k]), 32'(rq));
        if (rq) chk("mem_addr", k, 32'(w_addr[k]), 32'(w_pc[k]));
        chk("pc_en", k, 32'(w_pc_en[k]), 32'(en));
        chk("pc_newAdr", k, 32'(w_newadr[k]), redir ? 32'(redir_adr) : 0);
        chk("pc_imm", k, 32'(w_imm[k]), redir ? 32'(redir_imm) : 0);
        chk("instr_valid", k, 32'(w_valid[k]), 32'(m_valid[k]));
        chk("instr", k, 32'(w_instr[k]), 32'(m_instr[k]));
        chk("instr_pc", k, 32'(w_ipc[k]), 32'(m_ipc[k]));
        if (redir) begin
          m_valid[k] = 1'b0;
          m_pend[k]  = 1'b0;
        end else if (rq) begin
          m_pend[k] = 1'b1;
          m_age[k]  = 1;
          m_fa[k]   = w_pc[k];
        end else if (cp) begin
          m_valid[k] = 1'b1;
          m_pend[k]  = 1'b0;
          m_instr[k] = 16'h1000 + m_fa[k];
          m_ipc[k]   = m_fa[k];
        end else if (m_pend[k]) begin
          m_age[k] = m_age[k] + 1;
        end else if (m_valid[k] && ready) begin
          m_valid[k] = 1'b0;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int npulse;
    int n;
    logic [15:0] p;
    #2 rst = 1'b0;

    repeat (3) begin
      cyc();
      ready     = 1'($urandom_range(0, 1));
      redir     = 1'($urandom_range(0, 1));
      redir_br  = 1'($urandom_range(0, 1));
      redir_adr = 16'($urandom);
      redir_imm = 16'($urandom);
      #3;
      chk("t1_rst_rd", 0, 32'(w_rd[0]), 0);
      chk("t1_rst_pc_en", 0, 32'(w_pc_en[0]), 0);
      chk("t1_rst_newadr", 0, 32'(w_newadr[0]), 0);
    end

    cyc();
    rst = 1'b1; redir = 1'b0; redir_br = 1'b0; redir_adr = '0; redir_imm = '0; ready = 1'b1;
    #3;
    chk("t1_first_req", 0, 32'(w_rd[0]), 1);
    chk("t1_first_addr", 0, 32'(w_addr[0]), 0);

    npulse = 0;
    for (int c = 1; c <= 13; c++) begin
      cyc();
      if (c == 6) ready = 1'b0;
      if (c == 13) ready = 1'b1;
      #3;
      if (c <= 8 && w_pc_en[0] == 2'b01) npulse++;
      if (c == 1 || c == 4 || c == 7) chk("t2_inc", 0, 32'(w_pc_en[0]), 1);
      if (c == 2 || c == 5 || c == 8) begin
        chk("t2_valid", 0, 32'(w_valid[0]), 1);
        chk("t2_instr", 0, 32'(w_instr[0]), 32'h1000 + 32'((c - 2) / 3));
        chk("t2_instr_pc", 0, 32'(w_ipc[0]), 32'((c - 2) / 3));
      end
      if (c >= 8 && c <= 12) begin
        chk("t3_hold_valid", 0, 32'(w_valid[0]), 1);
        chk("t3_hold_instr", 0, 32'(w_instr[0]), 32'h1002);
        chk("t3_hold_rd", 0, 32'(w_rd[0]), 0);
        chk("t3_hold_pc_en", 0, 32'(w_pc_en[0]), 0);
      end
    end
    chk("t2_pulse_count", 0, 32'(npulse), 3);

    cyc(); #3;
    chk("t3_req_after_ready", 0, 32'(w_rd[0]), 1);
    chk("t3_req_addr", 0, 32'(w_addr[0]), 3);
    chk("t4_l1_req_addr", 1, 32'(w_addr[1]), 2);

    cyc();
    cyc();
    redir = 1'b1; redir_br = 1'b0; redir_adr = 16'h0040;
    #3;
    chk("t4_jump_pc_en", 1, 32'(w_pc_en[1]), 2);
    chk("t4_jump_newadr", 1, 32'(w_newadr[1]), 32'h0040);
    chk("t4_jump_novalid", 1, 32'(w_valid[1]), 0);

    cyc();
    redir = 1'b0; redir_adr = '0;
    #3;
    chk("t4_next_rd", 1, 32'(w_rd[1]), 1);
    chk("t4_next_addr", 1, 32'(w_addr[1]), 32'h0040);
    chk("t4_no_inc", 1, 32'(w_pc_en[1]), 0);
    chk("t4_l0_addr", 0, 32'(w_addr[0]), 32'h0040);

    cyc();
    cyc();
    cyc();
    redir = 1'b1; redir_adr = 16'h0005;
    #3;
    chk("t5_req_redirect_rd", 0, 32'(w_rd[0]), 1);
    chk("t5_req_redirect_addr", 0, 32'(w_addr[0]), 32'h0041);
    chk("t5_req_redirect_en", 0, 32'(w_pc_en[0]), 2);

    cyc();
    redir = 1'b0; redir_adr = '0;
    #3;
    chk("t5_new_req_addr", 0, 32'(w_addr[0]), 5);

    cyc(); #3;
    chk("t5_cap_inc", 0, 32'(w_pc_en[0]), 1);

    cyc();
    redir = 1'b1; redir_br = 1'b1; redir_imm = 16'hFFFE;
    #3;
    chk("t5_hold_valid", 0, 32'(w_valid[0]), 1);
    chk("t5_hold_ipc", 0, 32'(w_ipc[0]), 5);
    chk("t5_hold_instr", 0, 32'(w_instr[0]), 32'h1005);
    chk("t5_branch_en", 0, 32'(w_pc_en[0]), 3);
    chk("t5_branch_imm", 0, 32'(w_imm[0]), 32'hFFFE);

    cyc();
    redir = 1'b0; redir_br = 1'b0; redir_imm = '0;
    #3;
    chk("t5_valid_fell", 0, 32'(w_valid[0]), 0);
    chk("t5_branch_rd", 0, 32'(w_rd[0]), 1);
    chk("t5_branch_addr", 0, 32'(w_addr[0]), 4);

    n = 0;
    do begin
      cyc(); #3;
      n++;
    end while (!w_rd[2] && n < 20);
    chk("t6_l2_req_seen", 2, 32'(w_rd[2]), 1);

    cyc();
    rst = 1'b0;
    #3;
    chk("t6_abort_rd", 2, 32'(w_rd[2]), 0);
    chk("t6_abort_pc_en", 2, 32'(w_pc_en[2]), 0);
    chk("t6_abort_valid", 2, 32'(w_valid[2]), 0);
    chk("t6_abort_instr", 2, 32'(w_instr[2]), 0);

    cyc();
    cyc();
    rst = 1'b1;
    p = w_pc[2];
    #3;
    chk("t6_fresh_rd", 2, 32'(w_rd[2]), 1);
    chk("t6_fresh_addr", 2, 32'(w_addr[2]), 32'(p));
    for (int k = 1; k <= 4; k++) begin
      cyc(); #3;
      chk("t6_cap_timing", 2, 32'(w_pc_en[2]), (k == 4) ? 1 : 0);
    end
    cyc(); #3;
    chk("t6_valid", 2, 32'(w_valid[2]), 1);
    chk("t6_instr", 2, 32'(w_instr[2]), 32'(16'h1000 + p));
    chk("t6_instr_pc", 2, 32'(w_ipc[2]), 32'(p));

    repeat (120) begin
      cyc();
      ready     = ($urandom_range(0, 3) != 0);
      redir     = ($urandom_range(0, 9) == 0);
      redir_br  = 1'($urandom_range(0, 1));
      redir_adr = redir ? 16'($urandom) : 16'h0;
      redir_imm = redir ? 16'($urandom) : 16'h0;
    end
    cyc();
    redir = 1'b0; redir_adr = '0; redir_imm = '0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
